sb_gbi_msg_scheduler: RTL
=========================

// Module: sb_gbi_msg_scheduler
// PURPOSE
//  Upstream feeder for the Xbee UART transmitter. Accepts GBI deposit events (colour, bin) from the
//  bot control FSM and queues them in a small FIFO. Drives the transmitter's level-sensitive
//  tx_start/field inputs one message at a time and waits for its done pulse. Enforces an
//  inter-message idle gap and a watchdog so a hung transmitter cannot stall the queue forever.
// PARAMETERS
//  DEPTH        4      FIFO entries, power of 2, 2..16
//  GAP_CYCLES   4340   clk_50M cycles of idle (tx_start=0) between messages (10 bit times @115200)
//  TIMEOUT      65000  max cycles in SEND waiting for done before abort; > 9 chars*11 bits*434
//  MSG_GBI      2'd1   msg_type code driven for GBI messages
// PORTS
//  clk_50M      in   1   50 MHz system clock
//  rst_n        in   1   asynchronous active-low reset
//  evt_valid    in   1   event strobe, sampled on rising clk_50M
//  evt_colour   in   2   0=Red(M) 1=Green(D) 2=Blue(W); 3 illegal
//  evt_bin      in   4   bin code 0..8 (0 encodes bin 9); 9..15 illegal
//  evt_ready    out  1   1 when FIFO not full
//  tx_start     out  1   level to transmitter; high for the whole message
//  colour       out  2   held stable while tx_start=1
//  bin_number   out  4   held stable while tx_start=1
//  msg_type     out  2   MSG_GBI while tx_start=1, else 0
//  msg_field    out  2   always 0 for GBI messages
//  tx_done      in   1   transmitter done; may be a pulse or a level
//  fifo_count   out  clog2(DEPTH)+1  entries queued, excluding the one in flight
//  overflow     out  1   sticky; set on evt_valid while full; cleared only by reset
//  bad_evt      out  1   one-cycle pulse when an illegal event is dropped
//  timeout_err  out  1   sticky; set on watchdog abort; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync deassert): all outputs 0 except evt_ready=1; FIFO empty; state IDLE.
//  Push: evt_valid & evt_ready & legal -> write {colour,bin} at the next edge.
//   Illegal event (colour==3 or bin>8): no write, bad_evt=1 for that cycle.
//   Event while full: no write, overflow<=1.
//  FSM states: IDLE, LOAD, SEND, GAP.
//   IDLE: if FIFO non-empty -> LOAD.
//   LOAD: pop the FIFO head into the output registers (colour, bin_number, msg_type=MSG_GBI);
//    tx_start stays 0 this cycle; -> SEND.
//   SEND: tx_start=1, fields frozen, watchdog counts.
//    First rising edge of tx_done (registered, edge-detected) -> tx_start=0, msg_type=0 -> GAP.
//    Watchdog reaches TIMEOUT-1 -> timeout_err<=1, tx_start=0 -> GAP. The entry is dropped.
//   GAP: tx_start=0 for exactly GAP_CYCLES cycles, then -> IDLE.
//    A tx_done still held high does not retrigger anything.
//  Latency: an event pushed into an empty FIFO while in IDLE gives tx_start=1 three edges later
//   (push, LOAD, SEND).
//  Simultaneous push and pop on a full FIFO: the pop frees the slot only at the next edge, so the
//   push is refused and sets overflow. This is deterministic; evt_ready is registered from count.
//  Simultaneous push and pop otherwise: both occur; fifo_count is unchanged.
//  Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
//  tx_done seen outside SEND is ignored.
//  rst_n low mid-message: tx_start drops asynchronously and the in-flight entry is lost.
//  Counters saturate; they never wrap inside a state.
// STRUCTURE
//  sb_pkg.vh: colour codes, MSG_GBI/msg_field codes, FSM state encodings, BPC=434.
//  One sub-module: sb_sync_fifo (DEPTH, WIDTH=6), with push/pop/full/empty/count.
//  The scheduler FSM, watchdog counter and gap counter stay in this module.
// TESTING
//  1 Push (1,4) -> 3 edges later tx_start=1, colour=1, bin_number=4, msg_type=1;
//    pulse tx_done -> tx_start=0 next edge; next tx_start no earlier than GAP_CYCLES later.
//  2 Push 5 events back-to-back with DEPTH=4 and tx_done held low -> 1 in flight, 4 queued,
//    evt_ready=0, 6th push sets overflow=1.
//  3 Push (3,2) and (0,12) -> two bad_evt pulses, fifo_count stays 0, tx_start never rises.
//  4 Never assert tx_done (TIMEOUT=100) -> tx_start falls after 100 cycles in SEND,
//    timeout_err=1, next queued entry still sent.
//  5 Assert rst_n=0 mid-SEND -> tx_start=0 with no clock edge; after release all outputs at reset
//    values, FIFO empty.
//  6 Hold tx_done high for 50 cycles -> exactly one message completes, no double pop;
//    end-to-end with SB3647_Xbee_Transmiter decodes "GBI4-D-#".

Source files
------------

// File: rtl/sb_gbi_msg_scheduler_pkg.sv
// Shared types and constants for the GBI message scheduler slice.
package sb_gbi_msg_scheduler_pkg;

    // Clock cycles per UART bit at 115200 baud from a 50 MHz clock
    localparam int BPC           = 434;
    // Bit times of idle line enforced between two messages
    localparam int GAP_BIT_TIMES = 10;

    // Highest legal bin code (bin 9 is encoded as 0)
    localparam logic [3:0] MAX_BIN = 4'd8;

    // msg_type / msg_field codes understood by the Xbee transmitter
    localparam logic [1:0] MSG_GBI_CODE  = 2'd1;
    localparam logic [1:0] MSG_FIELD_GBI = 2'd0;

    // Width of one queued event: {colour, bin}
    localparam int EVT_W = 6;

    typedef enum logic [1:0] {
        COLOUR_RED     = 2'd0,
        COLOUR_GREEN   = 2'd1,
        COLOUR_BLUE    = 2'd2,
        COLOUR_ILLEGAL = 2'd3
    } colour_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [1:0] colour;
        logic [3:0] bin;
    } gbi_evt_t;

    // An event is usable only with a real colour and a bin code 0..8
    function automatic logic evt_is_legal(input logic [1:0] colour, input logic [3:0] bin);
        return (colour != COLOUR_ILLEGAL) && (bin <= MAX_BIN);
    endfunction

endpackage

// File: rtl/sb_gbi_msg_scheduler_fifo.sv
// Small synchronous FIFO holding pending GBI events; count is registered so
// full/empty never depend combinationally on the same-cycle push or pop.
module sb_gbi_msg_scheduler_fifo
    import sb_gbi_msg_scheduler_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = EVT_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
)(
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk_50M) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sb_gbi_msg_scheduler.sv
// Queues GBI deposit events and feeds them one at a time to the Xbee UART
// transmitter, with a mandatory idle gap and a watchdog against a hung sender.
module sb_gbi_msg_scheduler
    import sb_gbi_msg_scheduler_pkg::*;
#(
    parameter  int         DEPTH      = 4,
    parameter  int         GAP_CYCLES = GAP_BIT_TIMES * BPC,
    parameter  int         TIMEOUT    = 65000,
    parameter  logic [1:0] MSG_GBI    = MSG_GBI_CODE,
    localparam int         CW         = $clog2(DEPTH) + 1
)(
    input  logic          clk_50M,
    input  logic          rst_n,
    input  logic          evt_valid,
    input  logic [1:0]    evt_colour,
    input  logic [3:0]    evt_bin,
    output logic          evt_ready,
    output logic          tx_start,
    output logic [1:0]    colour,
    output logic [3:0]    bin_number,
    output logic [1:0]    msg_type,
    output logic [1:0]    msg_field,
    input  logic          tx_done,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    output logic          bad_evt,
    output logic          timeout_err
);

    localparam int             WD_W     = $clog2(TIMEOUT + 1);
    localparam int             GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    sched_state_e     state;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             tx_done_prev;
    logic             done_rise;
    logic             evt_legal;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    gbi_evt_t         push_evt;
    gbi_evt_t         head_evt;

    assign evt_legal = evt_is_legal(evt_colour, evt_bin);
    assign push_evt  = {evt_colour, evt_bin};
    assign fifo_push = evt_valid & evt_legal;
    assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;
    assign evt_ready = ~fifo_full;
    assign msg_field = MSG_FIELD_GBI;
    assign done_rise = tx_done & ~tx_done_prev;

    sb_gbi_msg_scheduler_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_evt),
        .pop       (fifo_pop),
        .pop_data  (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Remember last tx_done so only a fresh rising edge can end a message
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            tx_done_prev <= 1'b0;
        end else begin
            tx_done_prev <= tx_done;
        end
    end

    // Input error flags: bad_evt pulses per dropped illegal event, overflow is sticky
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            bad_evt  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            bad_evt <= evt_valid & ~evt_legal;
            if (evt_valid & fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Message sequencer: pick up head, present fields, hold start, then enforce the idle gap
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tx_start    <= 1'b0;
            colour      <= '0;
            bin_number  <= '0;
            msg_type    <= '0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        colour     <= head_evt.colour;
                        bin_number <= head_evt.bin;
                        msg_type   <= MSG_GBI;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_start <= 1'b1;
                    wd_cnt   <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (done_rise) begin
                        tx_start <= 1'b0;
                        msg_type <= '0;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end else if (wd_cnt == WD_LAST) begin
                        tx_start    <= 1'b0;
                        msg_type    <= '0;
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= ST_GAP;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
